// File: rtl/ps2_host_rx_fifo.sv
// PS/2 host receiver: pin synchronisers, clock deglitch filter, 11-bit frame deframer and FWFT byte FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC cycles (err_type 11).
module ps2_host_rx_fifo #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 4,
    parameter int unsigned TIMEOUT_CYC = 2000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       error,
    output logic [1:0]                 err_type,
    output logic                       overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || FILTER < 1 || TIMEOUT_CYC < 1)
    begin : g_bad_params
        $error("ps2_host_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   fclk;
    logic [FW-1:0]          fcnt;
    logic                   clk_s, din, fall_c;
    state_t                 state;
    logic [7:0]             shreg;
    logic [2:0]             bitcnt;
    logic                   par_bit;
    logic                   push_c, pop_c, full_c, wr_c;
    logic [7:0]             mem [DEPTH];
    logic [AW-1:0]          wptr, rptr;
    logic [CW-1:0]          cnt_nxt;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign din    = data_sync[SYNC_STAGES-1];
    assign fall_c = fclk && !clk_s && (fcnt == FW'(FILTER - 1));

    // Pin synchronisers, idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Accept a new clock level only after FILTER consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fclk <= 1'b1;
            fcnt <= '0;
        end else if (clk_s != fclk) begin
            if (fcnt == FW'(FILTER - 1)) begin
                fclk <= clk_s;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end else begin
            fcnt <= '0;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_c;

    assign timeout_c = (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (fall_c || state == S_IDLE)
            tcnt <= '0;
        else if (tcnt != TW'(TIMEOUT_CYC))
            tcnt <= tcnt + TW'(1);
    end
`else
    logic timeout_c;
    assign timeout_c = 1'b0;
`endif

    assign push_c = fall_c && (state == S_STOP) && din && (^{shreg, par_bit});

    // Frame deframer, one transition per accepted falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            par_bit  <= 1'b0;
            error    <= 1'b0;
            err_type <= 2'b00;
        end else begin
            error    <= 1'b0;
            err_type <= 2'b00;
            if (fall_c) begin
                case (state)
                    S_IDLE: begin
                        if (!din) begin
                            state  <= S_DATA;
                            bitcnt <= '0;
                        end else begin
                            error    <= 1'b1;
                            err_type <= 2'b10;
                        end
                    end
                    S_DATA: begin
                        shreg  <= {din, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= din;
                        state   <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if (!din) begin
                            error    <= 1'b1;
                            err_type <= 2'b10;
                        end else if (!(^{shreg, par_bit})) begin
                            error    <= 1'b1;
                            err_type <= 2'b01;
                        end
                    end
                endcase
            end else if (timeout_c) begin
                state    <= S_IDLE;
                error    <= 1'b1;
                err_type <= 2'b11;
            end
        end
    end

    assign pop_c  = rd_en && (count != '0);
    assign full_c = (count == CW'(DEPTH));
    assign wr_c   = push_c && (!full_c || pop_c);

    always_comb begin
        cnt_nxt = count;
        if (wr_c && !pop_c)
            cnt_nxt = count + CW'(1);
        else if (!wr_c && pop_c)
            cnt_nxt = count - CW'(1);
    end

    // FWFT storage; a pop in the same cycle frees the slot for a push into a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_c && full_c && !pop_c;
            if (wr_c) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + AW'(1);
            end
            if (pop_c)
                rptr <= rptr + AW'(1);
            count    <= cnt_nxt;
            rd_valid <= (cnt_nxt != '0);
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: tb/tb_ps2_host_rx_fifo.sv
// Directed bench for ps2_host_rx_fifo: table of frames plus hand sequences for overflow, glitches, reset and timeout.
module tb_ps2_host_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data, rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       error;
    logic [1:0] err_type;
    logic       overflow;

    ps2_host_rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .error(error),
        .err_type(err_type), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_fail = 0;
    int err_seen = 0, ovf_seen = 0, proto_bad = 0;
    logic [1:0] last_err = 2'b00;
    logic prev_err = 1'b0, prev_ovf = 1'b0;

    // Pulse monitor: counts error/overflow pulses and flags multi-cycle pulses or stray err_type
    always @(negedge clk) begin
        if (error) begin
            err_seen = err_seen + 1;
            last_err = err_type;
        end
        if (overflow) ovf_seen = ovf_seen + 1;
        if ((error && prev_err) || (overflow && prev_ovf) || (!error && err_type != 2'b00))
            proto_bad = proto_bad + 1;
        prev_err = error;
        prev_ovf = overflow;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic pop_on_fall);
        ps2_data = b;
        cyc(5);
        ps2_clk = 1'b0;
        if (pop_on_fall) begin
            cyc(5);
            rd_en = 1'b1;
            cyc(1);
            rd_en = 1'b0;
            cyc(4);
        end else begin
            cyc(10);
        end
        ps2_clk = 1'b1;
        cyc(5);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic flip, input logic stop);
        return {stop, (~^d) ^ flip, d, 1'b0};
    endfunction

    task automatic send_range(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(f[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input logic pop_at_stop);
        logic [10:0] f;
        f = frame_bits(d, flip, stop);
        send_range(f, 0, 9);
        send_bit(f[10], pop_at_stop);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       flip;
        logic       stop;
        logic [1:0] exp_err;
        int         exp_cnt;
        logic [7:0] exp_head;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int e0, o0, n;
        logic [10:0] f;
        logic [7:0] drain [4];

        tbl[0] = '{8'hA8, 1'b1, 1'b1, 2'b01, 0, 8'h00};
        tbl[1] = '{8'h5A, 1'b0, 1'b0, 2'b10, 0, 8'h00};
        tbl[2] = '{8'h3C, 1'b0, 1'b1, 2'b00, 1, 8'h3C};
        tbl[3] = '{8'h12, 1'b0, 1'b1, 2'b00, 2, 8'h3C};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 2'b00, 3, 8'h3C};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 2'b00, 4, 8'h3C};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 2'b01, 4, 8'h3C};
        drain[0] = 8'h3C; drain[1] = 8'h12; drain[2] = 8'hFF; drain[3] = 8'h00;

        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        cyc(3);
        chk("reset count", int'(count), 0);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset rd_data", int'(rd_data), 0);
        chk("reset error", int'(error), 0);
        chk("reset err_type", int'(err_type), 0);
        chk("reset overflow", int'(overflow), 0);
        rst_n = 1'b1;
        cyc(5);

        // Single good byte then pop
        e0 = err_seen;
        send_frame(8'hA8, 1'b0, 1'b1, 1'b0);
        chk("A8 count", int'(count), 1);
        chk("A8 rd_valid", int'(rd_valid), 1);
        chk("A8 rd_data", int'(rd_data), 8'hA8);
        chk("A8 no error", err_seen - e0, 0);
        pop();
        chk("A8 pop count", int'(count), 0);
        chk("A8 pop rd_valid", int'(rd_valid), 0);

        for (int i = 0; i < 7; i++) begin
            e0 = err_seen;
            send_frame(tbl[i].d, tbl[i].flip, tbl[i].stop, 1'b0);
            chk($sformatf("vec%0d errors", i), err_seen - e0, (tbl[i].exp_err != 2'b00) ? 1 : 0);
            if (tbl[i].exp_err != 2'b00)
                chk($sformatf("vec%0d err_type", i), int'(last_err), int'(tbl[i].exp_err));
            chk($sformatf("vec%0d count", i), int'(count), tbl[i].exp_cnt);
            chk($sformatf("vec%0d rd_valid", i), int'(rd_valid), (tbl[i].exp_cnt != 0) ? 1 : 0);
            if (tbl[i].exp_cnt != 0)
                chk($sformatf("vec%0d head", i), int'(rd_data), int'(tbl[i].exp_head));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), int'(rd_data), int'(drain[i]));
            pop();
        end
        chk("drain count", int'(count), 0);

        // Overflow on the 9th byte
        o0 = ovf_seen;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        chk("ovf pulses", ovf_seen - o0, 1);
        chk("ovf count", int'(count), 8);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf read%0d", i), int'(rd_data), i);
            pop();
        end
        chk("ovf drained", int'(count), 0);

        // Full FIFO with a pop coinciding with the push
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        o0 = ovf_seen;
        send_frame(8'h09, 1'b0, 1'b1, 1'b1);
        chk("fullpop no ovf", ovf_seen - o0, 0);
        chk("fullpop count", int'(count), 8);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("fullpop read%0d", i), int'(rd_data), i);
            pop();
        end
        chk("fullpop drained", int'(count), 0);

        // Glitches shorter than the filter window, idle and mid-frame
        e0 = err_seen;
        ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(20);
        chk("idle glitch errors", err_seen - e0, 0);
        f = frame_bits(8'h3C, 1'b0, 1'b1);
        send_range(f, 0, 4);
        ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(5);
        send_range(f, 5, 10);
        chk("glitch errors", err_seen - e0, 0);
        chk("glitch count", int'(count), 1);
        chk("glitch data", int'(rd_data), 8'h3C);
        pop();

        // Reset mid-frame with a byte buffered
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        e0 = err_seen;
        f = frame_bits(8'h12, 1'b0, 1'b1);
        send_range(f, 0, 3);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst count", int'(count), 0);
        chk("midrst rd_valid", int'(rd_valid), 0);
        chk("midrst rd_data", int'(rd_data), 0);
        chk("midrst error", int'(error), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        chk("postrst errors", err_seen - e0, 0);
        chk("postrst count", int'(count), 1);
        chk("postrst data", int'(rd_data), 8'h12);
        pop();

`ifdef PS2_RX_TIMEOUT_EN
        // Stall after four data bits
        e0 = err_seen;
        f = frame_bits(8'h5A, 1'b0, 1'b1);
        send_range(f, 0, 4);
        n = 0;
        while (err_seen == e0 && n < 2500) begin
            cyc(1);
            n++;
        end
        chk("timeout errors", err_seen - e0, 1);
        chk("timeout err_type", int'(last_err), 3);
        chk("timeout latency window", int'(n >= 1950 && n <= 2050), 1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("after timeout count", int'(count), 1);
        chk("after timeout data", int'(rd_data), 8'h5A);
        pop();
`else
        n = 0;
`endif

        cyc(5);
        chk("pulse protocol", proto_bad, n - n);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule

// File: doc/ps2_host_rx_fifo.md
# ps2_host_rx_fifo

Parametrised PS/2 host receiver: synchronises and deglitches the keyboard `ps2_clk`/`ps2_data` lines and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). Good bytes are buffered in a DEPTH-entry first-word-fall-through FIFO read by the system side. Bad frames are classified and reported. It sits between the keyboard pins and the LC3 keyboard-data register logic, replacing the single-byte `cmd`/`cmd_rdy` host.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `SYNC_STAGES`, 2, flops in each pin synchroniser; ≥2
- `FILTER`, 4, consecutive `clk` cycles a synchronised `ps2_clk` level must hold before it is accepted; ≥1
- `TIMEOUT_CYC`, 2000, `clk` cycles without an accepted falling edge before an open frame is aborted (only with the macro)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ps2_clk`  in  1  keyboard clock pin, asynchronous
- `ps2_data`  in  1  keyboard data pin, asynchronous
- `rd_en`  in  1  pop head entry; ignored when `rd_valid`=0
- `rd_data`  out  8  head byte; valid when `rd_valid`=1
- `rd_valid`  out  1  FIFO non-empty
- `count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- `error`  out  1  one-cycle pulse on a rejected frame
- `err_type`  out  2  valid with `error`: 01 parity, 10 framing, 11 timeout; 00 otherwise
- `overflow`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full

## Operation
- Both pins pass through SYNC_STAGES flops. Synchroniser flops reset to 1.
- Filtered clock `fclk` resets to 1. It takes the synchronised `ps2_clk` value after that value has differed from `fclk` for FILTER consecutive cycles. Any agreeing cycle restarts the count.
- A falling edge is `fclk` going 1→0. On that cycle, synchronised `ps2_data` is the sampled bit.
- FSM, one transition per falling edge:
  - IDLE: bit=0 → DATA with bit counter 0. Bit=1 → stay in IDLE, `error` with `err_type`=10.
  - DATA: shift the bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: go to IDLE, then check in this order:
    - stop bit = 0 → framing error (10)
    - else the 9 data+parity bits have an even number of ones → parity error (01)
    - else push the byte
- A rejected byte is never pushed.
- Push when full: the byte is dropped and `overflow` pulses. If `rd_en` is active in the same cycle, the pop frees the slot and the push succeeds; `count` is unchanged.
- Push and pop in the same cycle when not full: both take effect; `count` is unchanged.
- FIFO pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- `rd_data` is the head entry combinationally from storage. It reads 0 when empty after reset.

## Timing
- Reset: FSM in IDLE; FIFO empty; `rd_valid`, `count`, `error`, `err_type`, `overflow` = 0; `rd_data` = 0.
- A pin change reaches `fclk` SYNC_STAGES+FILTER cycles later.
- The stop-bit falling edge is cycle N:
  - `rd_valid`/`count` update at N+1.
  - `error`/`err_type` or `overflow` are registered and pulse during cycle N+1 only.
- Pop: `rd_en` sampled at edge N; head advances and `count` decrements at N+1.
- Reset asserted mid-frame discards the partial frame and all FIFO contents immediately. No error is reported.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A counter clears on every accepted falling edge and counts while the FSM is not in IDLE.
  - On reaching TIMEOUT_CYC the FSM returns to IDLE, the partial byte is discarded, and `error` pulses with `err_type`=11 on the next cycle.
- Not defined: no counter. A truncated frame holds the FSM until further edges arrive. `err_type` 11 is never produced.

## Test plan
- Frame 0xA8 (parity bit 0, stop 1) → `rd_valid`=1, `rd_data`=0xA8, `count`=1; `rd_en` for one cycle → `count`=0, `rd_valid`=0.
- Frame 0xA8 with parity bit 1 → one-cycle `error`, `err_type`=01, `count` stays 0. Frame 0x5A with stop bit 0 → `err_type`=10.
- DEPTH=8: send 0x01..0x09 with no reads → `overflow` pulses on the 9th byte, `count`=8. Reads return 0x01..0x08 in order.
- Full FIFO with `rd_en` asserted in the 0x09 push cycle → no `overflow`, `count`=8, last read returns 0x09.
- FILTER=4: 2-cycle low glitch on `ps2_clk` during IDLE and mid-frame → no state change. Subsequent frame 0x3C received intact.
- With `PS2_RX_TIMEOUT_EN` and TIMEOUT_CYC=2000: stop the clock after 4 data bits → `error`/`err_type`=11 about 2001 cycles after the last edge. Next frame 0x5A received correctly. Reset asserted mid-frame → outputs at reset values, then 0x12 received correctly.
